// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings and control-pattern constants for the pipeline sequencer.
package pipe_stall_ctrl_pkg;

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_IMEM_WAIT = 3'd1;
    localparam logic [2:0] ST_DMEM_WAIT = 3'd2;
    localparam logic [2:0] ST_FLUSH     = 3'd3;
    localparam logic [2:0] ST_HALT      = 3'd4;

    typedef enum logic [2:0] {
        StRun      = ST_RUN,
        StImemWait = ST_IMEM_WAIT,
        StDmemWait = ST_DMEM_WAIT,
        StFlush    = ST_FLUSH,
        StHalt     = ST_HALT
    } state_e;

    localparam logic [15:0] NOP_INSTR = 16'b0000100000000000;

    typedef struct packed {
        logic pc_we;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_bubble;
        logic back_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN      = pipe_ctrl_t'(5'b11001);
    localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(5'b00000);
    localparam pipe_ctrl_t CTRL_RESET    = pipe_ctrl_t'(5'b01111);
    localparam pipe_ctrl_t CTRL_IMEM     = pipe_ctrl_t'(5'b01101);
    localparam pipe_ctrl_t CTRL_LOAD_USE = pipe_ctrl_t'(5'b00011);
    localparam pipe_ctrl_t CTRL_REDIRECT = pipe_ctrl_t'(5'b11101);

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Saturating count of consecutive non-advancing cycles with a sticky limit flag.
module stall_watchdog #(
    parameter int unsigned STALL_CNT_W    = 8,
    parameter int unsigned WATCHDOG_LIMIT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pc_we_i,
    input  logic                   halt_state_i,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   watchdog_err_o
);

    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pc_we_i) begin
            cnt_d = '0;
        end else if (!halt_state_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | (cnt_d == STALL_CNT_W'(WATCHDOG_LIMIT));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign stall_cnt_o    = cnt_q;
    assign watchdog_err_o = err_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencer: folds halt, data/instr stalls, redirects and load-use into one control set.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned STALL_CNT_W    = 8,
    parameter int unsigned WATCHDOG_LIMIT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   imem_stall_i,
    input  logic                   dmem_stall_i,
    input  logic                   redirect_i,
    input  logic                   load_use_i,
    input  logic                   halt_in_i,
    output logic                   pc_we_o,
    output logic                   if_id_en_o,
    output logic                   if_id_flush_o,
    output logic                   id_ex_bubble_o,
    output logic                   back_en_o,
    output logic                   halted_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   watchdog_err_o
);

    state_e     state_q, state_d;
    logic       pend_q, pend_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic       halted_q, halted_d;
    pipe_ctrl_t ctrl;

    always_comb begin
        ctrl        = CTRL_RUN;
        state_d     = state_q;
        pend_d      = pend_q;
        flush_cnt_d = flush_cnt_q;
        halted_d    = halted_q;
        if (!rst_ni) begin
            ctrl = CTRL_RESET;
        end else if (state_q == StHalt || halt_in_i) begin
            ctrl     = CTRL_FREEZE;
            state_d  = StHalt;
            halted_d = 1'b1;
        end else if (dmem_stall_i) begin
            ctrl    = CTRL_FREEZE;
            state_d = StDmemWait;
            pend_d  = pend_q | redirect_i;
        end else if (state_q == StImemWait && imem_stall_i) begin
            // Target is written now; the fetch still in flight belongs to the old path.
            ctrl       = CTRL_IMEM;
            ctrl.pc_we = redirect_i;
            pend_d     = pend_q | redirect_i;
        end else if (redirect_i || (pend_q && state_q != StImemWait)) begin
            ctrl        = CTRL_REDIRECT;
            pend_d      = 1'b0;
            flush_cnt_d = 3'(FLUSH_CYCLES - 1);
            state_d     = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else if (state_q == StImemWait && pend_q) begin
            // Stale instruction returned; drop it and fetch the captured target next.
            ctrl    = CTRL_IMEM;
            pend_d  = 1'b0;
            state_d = StRun;
        end else if (imem_stall_i) begin
            ctrl        = CTRL_IMEM;
            flush_cnt_d = 3'd0;
            state_d     = StImemWait;
        end else if (state_q == StFlush) begin
            ctrl        = CTRL_REDIRECT;
            flush_cnt_d = (flush_cnt_q == 3'd0) ? 3'd0 : flush_cnt_q - 3'd1;
            state_d     = (flush_cnt_q <= 3'd1) ? StRun : StFlush;
        end else if (load_use_i) begin
            ctrl    = CTRL_LOAD_USE;
            state_d = StRun;
        end else begin
            state_d = StRun;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StRun;
            pend_q      <= 1'b0;
            flush_cnt_q <= 3'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= halted_d;
        end
    end

    stall_watchdog #(
        .STALL_CNT_W   (STALL_CNT_W),
        .WATCHDOG_LIMIT(WATCHDOG_LIMIT)
    ) u_stall_watchdog (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pc_we_i       (ctrl.pc_we),
        .halt_state_i  (state_q == StHalt),
        .stall_cnt_o   (stall_cnt_o),
        .watchdog_err_o(watchdog_err_o)
    );

    assign pc_we_o        = ctrl.pc_we;
    assign if_id_en_o     = ctrl.if_id_en;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_bubble_o = ctrl.id_ex_bubble;
    assign back_en_o      = ctrl.back_en;
    assign halted_o       = halted_q;

endmodule
